fp_square_arbiter: RTL and testbench

- Shares one combinational fp_square unit among NREQ requesters in the vector-norm datapath. Lanes include element squaring and accumulator pre-scaling.
- Round-robin arbitration; the granted lane's operands are muxed onto the squarer.
- The 39-bit product (9-bit exp, 30-bit mantissa) is registered with its requester ID and returned over a valid/ready response port.
- Throughput is one square per cycle while the response port is not back-pressured.

---
 rtl/fp_sq_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/fp_square_arbiter.sv | 102 ++++++++++
 tb/tb_fp_square_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sq_pkg.sv
// Shared floating-point field layout for the squarer operand and product formats.
package fp_sq_pkg;

  localparam int FP_W   = 24;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 15;
  localparam int PROD_W = 39;
  localparam int PEXP_W = 9;
  localparam int PMAN_W = 30;

  // Operand field offsets: {sign, exp, mantissa}.
  localparam int SIGN_POS = FP_W - 1;
  localparam int EXP_LSB  = MAN_W;
  localparam int MAN_LSB  = 0;

  // Product field offsets: {exp, mantissa}, no sign.
  localparam int PEXP_LSB = PMAN_W;
  localparam int PMAN_LSB = 0;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  typedef struct packed {
    logic [PEXP_W-1:0] exp;
    logic [PMAN_W-1:0] man;
  } prod_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, combinationally.
// The pointer moves past the granted lane only when the caller reports a completed handshake.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  localparam logic [ID_W:0]   NREQ_V = (ID_W+1)'(NREQ);
  localparam logic [ID_W-1:0] LAST   = ID_W'(NREQ - 1);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   idx;
  logic            found;

  // Scan lanes ptr, ptr+1, ... modulo NREQ; the one-extra-bit sum avoids overflow before the wrap.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= NREQ_V) idx = idx - NREQ_V;
      if (enable && !found && req[idx[ID_W-1:0]]) begin
        found                  = 1'b1;
        gnt[idx[ID_W-1:0]]     = 1'b1;
        gnt_id                 = idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_id == LAST) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/fp_square_arbiter.sv
// Shares one external fp_square among NREQ lanes round-robin; one-cycle registered response, a stalled response blocks all grants.
// Optional per-lane grant statistics are built when FP_SQ_STATS_EN is defined.
module fp_square_arbiter
  import fp_sq_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int FP_W   = fp_sq_pkg::FP_W,
  parameter int PROD_W = fp_sq_pkg::PROD_W,
  parameter int ID_W   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [FP_W-1:0]      sq_a,
  output logic [FP_W-1:0]      sq_b,
  input  logic [PROD_W-1:0]    sq_prod,
  output logic                 rsp_valid,
  output logic [PROD_W-1:0]    rsp_prod,
  output logic [ID_W-1:0]      rsp_id,
  input  logic                 rsp_ready
`ifdef FP_SQ_STATS_EN
  ,
  input  logic [ID_W-1:0]      stat_sel,
  input  logic                 stat_clr,
  output logic [15:0]          stat_cnt
`endif
);

  logic            can_load;
  logic            handshake;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;

  assign can_load = !rsp_valid || rsp_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .enable  (can_load && !reset),
    .advance (handshake),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign req_ready = gnt;
  assign handshake = |(req_valid & gnt);

  // Idle squarer inputs are zeroed so the external unit does not toggle on stale lane data.
  always_comb begin
    sq_a = '0;
    sq_b = '0;
    if (handshake) begin
      sq_a = req_a[int'(gnt_id)*FP_W +: FP_W];
      sq_b = req_b[int'(gnt_id)*FP_W +: FP_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
    end else if (can_load) begin
      rsp_valid <= handshake;
      if (handshake) begin
        rsp_prod <= sq_prod;
        rsp_id   <= gnt_id;
      end
    end
  end

`ifdef FP_SQ_STATS_EN
  logic [15:0] grant_cnt [NREQ];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else if (handshake && grant_cnt[gnt_id] != 16'hFFFF) begin
      grant_cnt[gnt_id] <= grant_cnt[gnt_id] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cnt <= '0;
    end else if (int'(stat_sel) < NREQ) begin
      stat_cnt <= grant_cnt[stat_sel];
    end else begin
      stat_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fp_square_arbiter.sv
// Randomized bench for fp_square_arbiter against a lane-level round-robin reference model.
module tb_fp_square_arbiter;

  localparam int NREQ   = 4;
  localparam int FP_W   = 24;
  localparam int PROD_W = 39;
  localparam int ID_W   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*FP_W-1:0] req_a, req_b;
  logic [NREQ-1:0]      req_ready;
  logic [FP_W-1:0]      sq_a, sq_b;
  logic [PROD_W-1:0]    sq_prod;
  logic                 rsp_valid;
  logic [PROD_W-1:0]    rsp_prod;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_ready;
`ifdef FP_SQ_STATS_EN
  logic [ID_W-1:0]      stat_sel;
  logic                 stat_clr;
  logic [15:0]          stat_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int                m_ptr;
  bit                m_vld;
  logic [PROD_W-1:0] m_prod;
  int                m_id;
  int                e_g;
  logic [NREQ-1:0]   e_ready;
  logic [FP_W-1:0]   e_sq_a, e_sq_b;

  always #5 clk = ~clk;

  // Stand-in for the external squarer: exponent sum and top 30 bits of the hidden-one mantissa product.
  function automatic logic [PROD_W-1:0] ref_sq(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [8:0]  e;
    logic [31:0] m;
    e = {1'b0, a[22:15]} + {1'b0, b[22:15]};
    m = 32'({1'b1, a[14:0]}) * 32'({1'b1, b[14:0]});
    return {e, m[31:2]};
  endfunction

  assign sq_prod = ref_sq(sq_a, sq_b);

  fp_square_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .sq_a      (sq_a),
    .sq_b      (sq_b),
    .sq_prod   (sq_prod),
    .rsp_valid (rsp_valid),
    .rsp_prod  (rsp_prod),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
`ifdef FP_SQ_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  function automatic int pick(input logic [NREQ-1:0] v);
    if (reset) return -1;
    if (m_vld && !rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++)
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic apply(input logic [NREQ-1:0] v, input logic rdy, input bit keep);
    @(negedge clk);
    req_valid = v;
    rsp_ready = rdy;
    if (!keep) begin
      for (int k = 0; k < NREQ; k++) begin
        req_a[k*FP_W +: FP_W] = 24'($urandom);
        req_b[k*FP_W +: FP_W] = 24'($urandom);
      end
    end
    #1;
    e_g     = pick(v);
    e_ready = '0;
    e_sq_a  = '0;
    e_sq_b  = '0;
    if (e_g >= 0) begin
      e_ready[e_g] = 1'b1;
      e_sq_a = req_a[e_g*FP_W +: FP_W];
      e_sq_b = req_b[e_g*FP_W +: FP_W];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_vld = 0; m_prod = '0; m_id = 0; m_ptr = 0;
    end else if (!m_vld || rsp_ready) begin
      if (e_g >= 0) begin
        m_vld  = 1;
        m_prod = ref_sq(e_sq_a, e_sq_b);
        m_id   = e_g;
        m_ptr  = (e_g + 1) % NREQ;
      end else begin
        m_vld = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply(4'hF, 1'b1, 0);
      n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      n_vec++; if (sq_a !== '0) begin n_err++; $display("FAIL reset_sq_a: got %h expected 0", sq_a); end
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      n_vec++; if (rsp_prod !== '0) begin n_err++; $display("FAIL reset_rsp_prod: got %h expected 0", rsp_prod); end
      n_vec++; if (rsp_id !== '0) begin n_err++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    end
    reset = 1'b0;
  endtask

  task automatic test_all_valid();
    for (int i = 0; i < 5; i++) begin
      apply(4'hF, 1'b1, 0);
      n_vec++; if (req_ready !== 4'(1 << (i % NREQ))) begin n_err++; $display("FAIL allv_req_ready: got %b expected lane %0d", req_ready, i % NREQ); end
      n_vec++; if (sq_a !== e_sq_a || sq_b !== e_sq_b) begin n_err++; $display("FAIL allv_sq_mux: got %h/%h expected %h/%h", sq_a, sq_b, e_sq_a, e_sq_b); end
      tick();
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL allv_rsp_valid: got %b expected 1", rsp_valid); end
      n_vec++; if (int'(rsp_id) != i % NREQ) begin n_err++; $display("FAIL allv_rsp_id: got %0d expected %0d", rsp_id, i % NREQ); end
      n_vec++; if (rsp_prod !== m_prod) begin n_err++; $display("FAIL allv_rsp_prod: got %h expected %h", rsp_prod, m_prod); end
    end
  endtask

  task automatic test_lane2();
    logic [FP_W-1:0] a, b;
    a = 24'b0_00000000_101000000000000;
    b = 24'b0_00000000_010000000000000;
    apply(4'b0000, 1'b1, 0);
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lane2_idle_valid: got %b expected 0", rsp_valid); end
    req_a[2*FP_W +: FP_W] = a;
    req_b[2*FP_W +: FP_W] = b;
    apply(4'b0100, 1'b1, 1);
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL lane2_req_ready: got %b expected 0100", req_ready); end
    n_vec++; if (sq_a !== a || sq_b !== b) begin n_err++; $display("FAIL lane2_sq_mux: got %h/%h expected %h/%h", sq_a, sq_b, a, b); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL lane2_rsp_valid: got %b expected 1", rsp_valid); end
    n_vec++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL lane2_rsp_id: got %0d expected 2", rsp_id); end
    n_vec++; if (rsp_prod !== ref_sq(a, b)) begin n_err++; $display("FAIL lane2_rsp_prod: got %h expected %h", rsp_prod, ref_sq(a, b)); end
  endtask

  task automatic test_backpressure();
    logic [PROD_W-1:0] held_prod;
    int held_id;
    apply(4'hF, 1'b1, 0);
    tick();
    held_prod = m_prod;
    held_id   = m_id;
    for (int c = 0; c < 5; c++) begin
      apply(4'($urandom_range(1, 15)), 1'b0, 0);
      n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL bp_req_ready: got %b expected 0000", req_ready); end
      tick();
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_rsp_valid: got %b expected 1", rsp_valid); end
      n_vec++; if (rsp_prod !== held_prod || int'(rsp_id) != held_id) begin n_err++; $display("FAIL bp_hold: got %h/%0d expected %h/%0d", rsp_prod, rsp_id, held_prod, held_id); end
    end
    apply(4'hF, 1'b1, 0);
    n_vec++; if (req_ready !== 4'(1 << ((held_id + 1) % NREQ))) begin n_err++; $display("FAIL bp_pop_grant: got %b expected lane %0d", req_ready, (held_id + 1) % NREQ); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1 || int'(rsp_id) != (held_id + 1) % NREQ) begin n_err++; $display("FAIL bp_b2b: got v=%b id=%0d expected v=1 id=%0d", rsp_valid, rsp_id, (held_id + 1) % NREQ); end
    n_vec++; if (rsp_prod !== m_prod) begin n_err++; $display("FAIL bp_b2b_prod: got %h expected %h", rsp_prod, m_prod); end
  endtask

  task automatic test_fairness();
    int hs;
    bit got3;
    hs = 0;
    got3 = 0;
    for (int c = 0; c < 10; c++) begin
      apply(4'b0001, 1'b1, 0);
      tick();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_err++; $display("FAIL fair_lane0: got v=%b id=%0d expected v=1 id=0", rsp_valid, rsp_id); end
    end
    for (int c = 0; c < 8 && !got3; c++) begin
      apply(4'b1001, 1'b1, 0);
      tick();
      if (rsp_valid === 1'b1) begin
        hs++;
        if (rsp_id === 2'd3) got3 = 1;
      end
    end
    n_vec++; if (!got3 || hs > NREQ) begin n_err++; $display("FAIL fair_lane3: got granted=%0d after %0d handshakes expected within %0d", got3, hs, NREQ); end
    for (int c = 0; c < 3; c++) begin
      apply(4'b0000, 1'b1, 0);
      tick();
    end
    apply(4'hF, 1'b1, 0);
    n_vec++; if (req_ready !== 4'(1 << ((m_id + 1) % NREQ))) begin n_err++; $display("FAIL fair_idle_ptr: got %b expected lane %0d", req_ready, (m_id + 1) % NREQ); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    apply(4'hF, 1'b1, 0);
    tick();
    apply(4'hF, 1'b0, 0);
    tick();
    reset = 1'b1;
    apply(4'hF, 1'b0, 0);
    n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL rstall_req_ready: got %b expected 0000", req_ready); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstall_rsp_valid: got %b expected 0", rsp_valid); end
    reset = 1'b0;
    apply(4'hF, 1'b1, 0);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rstall_ptr: got %b expected 0001", req_ready); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      apply(4'($urandom), logic'($urandom_range(0, 3) != 0), 0);
      n_vec++; if (req_ready !== e_ready) begin n_err++; $display("FAIL rnd_req_ready: cycle %0d got %b expected %b", c, req_ready, e_ready); end
      n_vec++; if (sq_a !== e_sq_a || sq_b !== e_sq_b) begin n_err++; $display("FAIL rnd_sq_mux: cycle %0d got %h/%h expected %h/%h", c, sq_a, sq_b, e_sq_a, e_sq_b); end
      tick();
      n_vec++; if (rsp_valid !== logic'(m_vld)) begin n_err++; $display("FAIL rnd_rsp_valid: cycle %0d got %b expected %b", c, rsp_valid, m_vld); end
      if (m_vld) begin
        n_vec++; if (rsp_prod !== m_prod || int'(rsp_id) != m_id) begin n_err++; $display("FAIL rnd_rsp: cycle %0d got %h/%0d expected %h/%0d", c, rsp_prod, rsp_id, m_prod, m_id); end
      end
    end
  endtask

`ifdef FP_SQ_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b1;
    apply(4'b0000, 1'b1, 0);
    tick();
    stat_clr = 1'b0;
    for (int c = 0; c < 20; c++) begin apply(4'b0010, 1'b1, 0); tick(); end
    for (int c = 0; c < 3; c++)  begin apply(4'b0001, 1'b1, 0); tick(); end
    stat_sel = 2'd1;
    apply(4'b0000, 1'b1, 0);
    tick();
    n_vec++; if (stat_cnt !== 16'd20) begin n_err++; $display("FAIL stat_lane1: got %0d expected 20", stat_cnt); end
    stat_sel = 2'd0;
    apply(4'b0000, 1'b1, 0);
    tick();
    n_vec++; if (stat_cnt !== 16'd3) begin n_err++; $display("FAIL stat_lane0: got %0d expected 3", stat_cnt); end
    stat_clr = 1'b1;
    apply(4'b0010, 1'b1, 0);
    tick();
    stat_clr = 1'b0;
    stat_sel = 2'd1;
    apply(4'b0000, 1'b1, 0);
    tick();
    n_vec++; if (stat_cnt !== 16'd0) begin n_err++; $display("FAIL stat_clr_prio: got %0d expected 0", stat_cnt); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    m_ptr = 0; m_vld = 0; m_prod = '0; m_id = 0; e_g = -1;
    e_ready = '0; e_sq_a = '0; e_sq_b = '0;
`ifdef FP_SQ_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
    test_reset();
    test_all_valid();
    test_lane2();
    test_backpressure();
    test_fairness();
    test_reset_mid_stall();
    test_random();
`ifdef FP_SQ_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
